// File: rtl/shift_issue_queue.sv
// Flow-controlled feeder for an external 8-bit combinational barrel shifter:
// command FIFO -> registered issue stage (drives shifter) -> result register.
module shift_issue_queue #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  in_data,
  input  logic [2:0]                  in_shift,
  input  logic                        in_dir,
  input  logic                        in_arith,
  output logic [7:0]                  sh_din,
  output logic [2:0]                  sh_shift,
  output logic                        sh_dir,
  output logic                        sh_arith,
  input  logic [7:0]                  sh_dout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  out_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]            done_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] shift;
    logic       dir;
    logic       arith;
  } cmd_t;

  cmd_t             mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  cmd_t             iss_q, iss_d;
  logic             iss_v_q, iss_v_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic             push, pop, out_free, iss_free, capture, out_hs;
  cmd_t             cmd_in;

  assign cmd_in   = '{data: in_data, shift: in_shift, dir: in_dir, arith: in_arith};
  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign in_ready = (count_q < DEPTH_C);

  always_comb begin
    out_free    = !out_valid_q || out_ready;
    iss_free    = !iss_v_q || out_free;
    push        = in_valid && in_ready;
    pop         = (count_q != '0) && iss_free;
    capture     = iss_v_q && out_free;
    out_hs      = out_valid_q && out_ready;

    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    iss_d   = iss_q;
    iss_v_d = iss_v_q;
    if (pop) begin
      iss_d   = mem_q[rd_ptr_q];
      iss_v_d = 1'b1;
    end else if (out_free) begin
      iss_v_d = 1'b0;
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (capture) begin
      out_data_d  = sh_dout;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    done_d = out_hs ? done_q + 1'b1 : done_q;
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      iss_q       <= '0;
      iss_v_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      done_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      iss_q       <= iss_d;
      iss_v_q     <= iss_v_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign sh_din     = iss_q.data;
  assign sh_shift   = iss_q.shift;
  assign sh_dir     = iss_q.dir;
  assign sh_arith   = iss_q.arith;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign fifo_count = count_q;
  assign done_count = done_q;

endmodule

// File: doc/shift_issue_queue.md
Name: shift_issue_queue

Overview:
- Upstream feeder for the 8-bit combinational barrel shifter (ports din/shift/dir/arith/dout).
- Accepts shift commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the shifter from a registered issue stage and captures its dout into an output register with its own valid/ready handshake.
- Turns the combinational shifter into a flow-controlled, back-pressurable pipeline unit. The shifter is instantiated outside this block.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, >=2.
- CNT_W, 8, width of the completed-result counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  FIFO can accept this cycle.
- in_data  input  8  operand.
- in_shift  input  3  shift amount 0..7.
- in_dir  input  1  0 = left, 1 = right.
- in_arith  input  1  0 = logic, 1 = arithmetic (right only).
- sh_din  output  8  to shifter din.
- sh_shift  output  3  to shifter shift.
- sh_dir  output  1  to shifter dir.
- sh_arith  output  1  to shifter arith.
- sh_dout  input  8  from shifter dout; combinational function of the sh_* outputs.
- out_valid  output  1  result register holds data.
- out_ready  input  1  consumer takes result.
- out_data  output  8  shifted result.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- done_count  output  CNT_W  results consumed, wraps modulo 2^CNT_W.

Behaviour:
- Reset, async assert and sync release:
  - FIFO pointers and fifo_count = 0.
  - Issue register valid (iss_v) = 0.
  - out_valid = 0, out_data = 0x00, done_count = 0.
  - sh_din = 0x00, sh_shift = 0, sh_dir = 0, sh_arith = 0.
  - Reset mid-operation discards all queued, issued and pending results; no partial output.
- in_ready = (fifo_count < FIFO_DEPTH).
  - Depends on registered state only; never combinationally on out_ready or on a same-cycle pop.
- Push: at the edge where in_valid & in_ready, {in_data, in_shift, in_dir, in_arith} is written at the write pointer; the pointer wraps modulo FIFO_DEPTH.
- Stage advance rules:
  - out_free = !out_valid | out_ready.
  - iss_free = !iss_v | out_free.
- Pop: when fifo_count > 0 and iss_free, the FIFO head loads into the issue register (sh_* outputs) and iss_v <= 1.
  - Otherwise, if out_free, iss_v <= 0.
  - The sh_* outputs hold their value while iss_v = 0.
- Capture: when iss_v & out_free, out_data <= sh_dout and out_valid <= 1.
  - Else if out_ready, out_valid <= 0.
- Simultaneous push and pop: both occur; fifo_count is unchanged.
  - When full, in_ready = 0, so only a pop can occur.
  - When empty, no pop occurs; a push occurring in the same cycle lands in the FIFO with no bypass.
- Latency:
  - Command accepted at edge E0 is issued at E1.
  - out_valid rises at E2 with the result; minimum 2 cycles.
- Throughput: 1 result per cycle with out_ready held high.
- Ordering: strict FIFO; results leave in acceptance order.
- Total capacity: FIFO_DEPTH + 2 commands (FIFO, issue, output) when out_ready is held low.
- done_count increments at every edge where out_valid & out_ready; wraps from 2^CNT_W−1 to 0.
- out_data and out_valid are stable while out_valid & !out_ready.
- The block itself has no shift arithmetic; correctness of out_data relies on the attached shifter.

Test Plan:
- Push {0x96, shift 2, left, logic} with out_ready = 1 -> sh_* presented one cycle after accept; out_valid two cycles after accept with out_data = 0x58; done_count = 1.
- Back-to-back pushes, out_ready = 1:
  - {0x96, 3, right, logic} -> 0x12.
  - {0x96, 3, right, arith} -> 0xF2.
  - {0x81, 0, left, arith} -> 0x81.
  - Required: in order, on consecutive cycles.
- Backpressure (FIFO_DEPTH = 4): out_ready = 0, stream 8 commands with in_valid held high -> exactly 6 accepted; in_ready low once fifo_count = 4; out_data frozen on the first result; then raise out_ready -> 6 results in order, one per cycle, in_ready reasserts the cycle after the first pop.
- Full FIFO with out_ready toggling 1/0 each cycle while in_valid is held -> no command lost or duplicated; fifo_count never exceeds 4; done_count equals the number of out handshakes.
- Assert rst mid-stream with 3 queued, 1 issued and 1 output pending -> immediately out_valid = 0, fifo_count = 0, done_count = 0, in_ready = 1; first post-reset command returns correctly at 2-cycle latency.
- done_count wrap (CNT_W = 8): 256 results consumed -> done_count returns to 0x00.
